bit_time_gen: RTL

BIT_TIME_GEN -- requirements
Module: bit_time_gen

---
 rtl/bit_time_gen.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/bit_time_gen.sv
// UART-style bit-time generator: btu / half_btu / ovs_tick pulses from a baud-indexed divisor.
// Optional oversample counter enabled by defining BIT_TIME_GEN_OVS_EN.
module bit_time_gen #(
   parameter int unsigned CLK_HZ = 100000000,
   parameter int unsigned CNT_W  = 19,
   parameter int unsigned OVS    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] sel,
   input  logic [3:0] baud,
   output logic       btu,
   output logic       half_btu,
   output logic       ovs_tick,
   output logic       busy
);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_ALIGN, S_SHOT, S_DONE} state_t;

   function automatic logic [CNT_W-1:0] div_of(input int unsigned rate);
      return CNT_W'((CLK_HZ + rate / 2) / rate);
   endfunction

   function automatic logic [CNT_W-1:0] ovs_div_of(input logic [CNT_W-1:0] d);
      logic [CNT_W-1:0] q;
      q = d / CNT_W'(OVS);
      return (q == '0) ? CNT_W'(1) : q;
   endfunction

   // Indices 12-15 fold onto 115200 baud.
   localparam logic [CNT_W-1:0] DIV_TAB [16] = '{
      div_of(300),    div_of(1200),   div_of(2400),   div_of(4800),
      div_of(9600),   div_of(19200),  div_of(38400),  div_of(57600),
      div_of(115200), div_of(230400), div_of(460800), div_of(921600),
      div_of(115200), div_of(115200), div_of(115200), div_of(115200)
   };

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_div;
   logic             r_btu;
   logic             r_half;
   logic             r_busy;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_div_nxt;
   logic [CNT_W-1:0] w_term;
   logic [CNT_W-1:0] w_term_nxt;
   logic [CNT_W-1:0] w_half_nxt;
   logic             w_run;
   logic             w_run_nxt;
   logic             w_end;
   logic             w_btu_nxt;
   logic             w_half_btu_nxt;

   // Next-state logic; pulses are registered from the next count so they line up with it.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = '0;
      w_div_nxt      = r_div;
      w_run          = (r_state == S_RUN) || (r_state == S_ALIGN) || (r_state == S_SHOT);
      w_term         = (r_state == S_ALIGN) ? ((r_div >> 1) - CNT_W'(1)) : (r_div - CNT_W'(1));
      w_end          = w_run && (r_cnt == w_term);
      w_run_nxt      = 1'b0;
      w_term_nxt     = '0;
      w_half_nxt     = '0;
      w_btu_nxt      = 1'b0;
      w_half_btu_nxt = 1'b0;

      case (r_state)
         S_IDLE: begin
            case (sel)
               2'b01:   w_state_nxt = S_RUN;
               2'b10:   w_state_nxt = S_ALIGN;
               2'b11:   w_state_nxt = S_SHOT;
               default: w_state_nxt = S_IDLE;
            endcase
         end
         S_RUN, S_ALIGN, S_SHOT: begin
            if (sel == 2'b00) begin
               w_state_nxt = S_IDLE;
            end else if (w_end) begin
               if (r_state == S_ALIGN)     w_state_nxt = S_RUN;
               else if (r_state == S_SHOT) w_state_nxt = S_DONE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_DONE: begin
            if (sel == 2'b00) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Baud changes only land at a bit boundary or while idle.
      if ((r_state == S_IDLE) || w_end) w_div_nxt = DIV_TAB[baud];

      w_run_nxt  = (w_state_nxt == S_RUN) || (w_state_nxt == S_ALIGN) || (w_state_nxt == S_SHOT);
      w_half_nxt = (w_div_nxt >> 1) - CNT_W'(1);
      w_term_nxt = (w_state_nxt == S_ALIGN) ? w_half_nxt : (w_div_nxt - CNT_W'(1));
      w_btu_nxt      = w_run_nxt && (w_cnt_nxt == w_term_nxt);
      w_half_btu_nxt = w_run_nxt && (w_state_nxt != S_ALIGN) && (w_cnt_nxt == w_half_nxt);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_div   <= '0;
         r_btu   <= 1'b0;
         r_half  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_div   <= w_div_nxt;
         r_btu   <= w_btu_nxt;
         r_half  <= w_half_btu_nxt;
         r_busy  <= w_run_nxt;
      end
   end

   assign btu      = r_btu;
   assign half_btu = r_half;
   assign busy     = r_busy;

`ifdef BIT_TIME_GEN_OVS_EN
   logic [CNT_W-1:0] r_ovs_cnt;
   logic             r_ovs_tick;
   logic [CNT_W-1:0] w_ovs_div;
   logic [CNT_W-1:0] w_ovs_div_nxt;
   logic [CNT_W-1:0] w_ovs_cnt_nxt;

   // Oversample counter restarts with every bit so ticks stay phase-locked to btu.
   always_comb begin
      w_ovs_div     = ovs_div_of(r_div);
      w_ovs_div_nxt = ovs_div_of(w_div_nxt);
      w_ovs_cnt_nxt = '0;
      if (w_run_nxt && !w_end && (r_state != S_IDLE) &&
          (r_ovs_cnt != (w_ovs_div - CNT_W'(1))))
         w_ovs_cnt_nxt = r_ovs_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ovs_cnt  <= '0;
         r_ovs_tick <= 1'b0;
      end else begin
         r_ovs_cnt  <= w_ovs_cnt_nxt;
         r_ovs_tick <= w_run_nxt && (w_ovs_cnt_nxt == (w_ovs_div_nxt - CNT_W'(1)));
      end
   end

   assign ovs_tick = r_ovs_tick;
`else
   assign ovs_tick = 1'b0;
`endif

endmodule
